// File: rtl/actmap_drain.sv
// actmap_drain: reads BRAM2 in address order and streams each word over valid/ready.
// A 2-entry buffer absorbs the one-cycle read latency, so no word is lost under backpressure.
module actmap_drain #(
  parameter int DATA_WIDTH      = 8,
  parameter int PE_SIZE         = 14,
  parameter int OUT_CH          = 64,
  parameter int MEM2_DATA_WIDTH = PE_SIZE*DATA_WIDTH,
  parameter int MEM2_DEPTH      = PE_SIZE*OUT_CH,
  parameter int MEM2_ADDR_WIDTH = $clog2(MEM2_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       drain_start_i,
  output logic                       drain_busy_o,
  output logic                       drain_done_o,
  output logic                       mem2_ce0_o,
  output logic                       mem2_we0_o,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr0_o,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q0_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
  output logic                       m_last_o
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
  localparam logic [MEM2_ADDR_WIDTH-1:0] LAST_ADDR = MEM2_ADDR_WIDTH'(MEM2_DEPTH-1);
  state_t                     state_q;
  logic [MEM2_ADDR_WIDTH-1:0] addr_q;
  logic                       inflight_q, inflight_last_q;
  logic [1:0]                 cnt_q, cnt_d, lvl;
  logic [MEM2_DATA_WIDTH:0]   entry0_q, entry1_q, entry0_d, entry1_d, push_w;
  logic                       pop, push, issue, at_end;
  logic [2:0]                 pend;
  // entries carry {last, data}; entry0 is the head presented downstream
  always_comb begin
    pop      = (cnt_q != 2'd0) & m_ready_i;
    push     = inflight_q;
    pend     = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    issue    = (state_q == READ) & (pend < 3'd2);
    at_end   = addr_q == LAST_ADDR;
    lvl      = cnt_q - 2'(pop);
    push_w   = {inflight_last_q, mem2_q0_i};
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
    entry0_d = (pop & (cnt_q == 2'd2)) ? entry1_q : (push & (lvl == 2'd0)) ? push_w : entry0_q;
    entry1_d = (push & (lvl == 2'd1)) ? push_w : entry1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cnt_q           <= 2'd0;
      entry0_q        <= '0;
      entry1_q        <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue & at_end;
      cnt_q           <= cnt_d;
      entry0_q        <= entry0_d;
      entry1_q        <= entry1_d;
      if (issue && !at_end) addr_q <= addr_q + 1'b1;
      case (state_q)
        IDLE: if (drain_start_i) begin
          state_q <= READ;
          addr_q  <= '0;
        end
        READ:  if (issue && at_end) state_q <= FLUSH;
        FLUSH: if (!inflight_q && cnt_q == 2'd1 && pop && entry0_q[MEM2_DATA_WIDTH]) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign drain_busy_o = (state_q == READ) | (state_q == FLUSH);
  assign drain_done_o = state_q == DONE;
  assign mem2_ce0_o   = issue;
  assign mem2_we0_o   = 1'b0;
  assign mem2_addr0_o = addr_q;
  assign m_valid_o    = cnt_q != 2'd0;
  assign m_data_o     = entry0_q[MEM2_DATA_WIDTH-1:0];
  assign m_last_o     = entry0_q[MEM2_DATA_WIDTH];
endmodule

// File: tb/tb_actmap_drain.sv
// tb_actmap_drain: directed drains against a BRAM2 model with a scoreboard of expected beats.
module tb_actmap_drain;
  localparam int DW = 8, PE = 14, OC = 64, W = PE*DW, D = PE*OC, AW = $clog2(D);
  logic clk = 1'b0, rst_n = 1'b0, drain_start_i = 1'b0, m_ready_i = 1'b0;
  logic drain_busy_o, drain_done_o, mem2_ce0_o, mem2_we0_o, m_valid_o, m_last_o;
  logic [AW-1:0] mem2_addr0_o;
  logic [W-1:0]  mem2_q0_i = '0, m_data_o;
  logic [W:0]    sb[$];
  logic [W:0]    prev_word, exp_w;
  int errors = 0, checks = 0, issued = 0, popped = 0, exp_addr = 0, cyc = 0, dones = 0;
  bit stall_prev = 0, tm = 0, got_done = 0;

  actmap_drain dut (
    .clk(clk), .rst_n(rst_n), .drain_start_i(drain_start_i), .drain_busy_o(drain_busy_o),
    .drain_done_o(drain_done_o), .mem2_ce0_o(mem2_ce0_o), .mem2_we0_o(mem2_we0_o),
    .mem2_addr0_o(mem2_addr0_o), .mem2_q0_i(mem2_q0_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {PE{b}};
  endfunction

  always @(posedge clk) if (mem2_ce0_o) mem2_q0_i <= word(int'(mem2_addr0_o));

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic cycle(input bit rdy);
    m_ready_i = rdy;
    #1;
    chk("pending_le2", (issued - popped) <= 2, 1);
    if (tm) begin
      chk("valid_timing", m_valid_o, cyc >= 3 && cyc <= 898);
      chk("busy_timing", drain_busy_o, cyc >= 1 && cyc <= 898);
      chk("done_timing", drain_done_o, cyc == 899);
    end
    if (stall_prev) begin
      chk("hold_valid", m_valid_o, 1);
      chk("hold_word", {m_last_o, m_data_o}, prev_word);
    end
    if (mem2_ce0_o) begin
      chk("read_addr", mem2_addr0_o, exp_addr);
      exp_addr++;
      issued++;
    end
    if (m_valid_o && m_ready_i) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("beat_data", m_data_o, exp_w[W-1:0]);
        chk("beat_last", m_last_o, exp_w[W]);
      end
      popped++;
    end
    if (drain_done_o) begin
      got_done = 1;
      dones++;
    end
    stall_prev = m_valid_o && !m_ready_i;
    prev_word  = {m_last_o, m_data_o};
    @(negedge clk);
    drain_start_i = 1'b0;
    cyc++;
  endtask

  task automatic arm();
    sb.delete();
    for (int k = 0; k < D; k++) sb.push_back({k == D-1, word(k)});
    issued = 0; popped = 0; exp_addr = 0; cyc = 0; dones = 0;
    stall_prev = 0; got_done = 0;
    drain_start_i = 1'b1;
  endtask

  task automatic run_to_done(input bit alt);
    for (int n = 0; n < 4000 && !got_done; n++) cycle(alt ? (n % 2 == 0) : 1'b1);
    chk("done_seen", got_done, 1);
    chk("all_beats", popped, D);
    chk("sb_empty", sb.size(), 0);
    chk("one_done", dones, 1);
  endtask

  initial begin
    // reset and idle behaviour
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", drain_busy_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", drain_busy_o, 0);
    chk("idle_done", drain_done_o, 0);
    chk("idle_ce0", mem2_ce0_o, 0);
    chk("idle_we0", mem2_we0_o, 0);
    chk("idle_addr", mem2_addr0_o, 0);
    chk("idle_data", m_data_o, 0);
    chk("idle_last", m_last_o, 0);
    for (int i = 0; i < 4; i++) begin
      m_ready_i = (i % 2 == 0);
      #1;
      chk("nostart_ce0", mem2_ce0_o, 0);
      chk("nostart_valid", m_valid_o, 0);
      cycle(i % 2 == 0);
    end
    // full-rate drain with cycle-exact timing
    tm = 1;
    arm();
    run_to_done(0);
    tm = 0;
    // alternating ready
    arm();
    run_to_done(1);
    // 20-cycle stall at beat 100
    arm();
    while (popped < 100 && cyc < 400) cycle(1);
    chk("reached_100", popped, 100);
    for (int i = 0; i < 20; i++) begin
      m_ready_i = 1'b0;
      #1;
      chk("stall_valid", m_valid_o, 1);
      chk("stall_data", m_data_o, word(100));
      if (i >= 2) chk("stall_ce0", mem2_ce0_o, 0);
      cycle(0);
    end
    for (int i = 0; i < 10; i++) begin
      m_ready_i = 1'b1;
      #1;
      chk("no_gap", m_valid_o, 1);
      cycle(1);
    end
    run_to_done(0);
    // ignored second start, then a fresh drain
    arm();
    while (popped < 50 && cyc < 200) cycle(1);
    drain_start_i = 1'b1;
    cycle(1);
    run_to_done(0);
    arm();
    run_to_done(0);
    // asynchronous reset mid-drain
    arm();
    while (popped < 400 && cyc < 600) cycle(1);
    chk("reached_400", popped, 400);
    m_ready_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", m_valid_o, 0);
    chk("abort_ce0", mem2_ce0_o, 0);
    chk("abort_busy", drain_busy_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    arm();
    run_to_done(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/actmap_drain.md
Name: actmap_drain

Overview:
Downstream stage of the GEMM core. On a start pulse, it reads the finished activation map out of BRAM2 through port 0 in address order, 0 to MEM2_DEPTH-1. It streams each 112-bit row word out on a valid/ready interface with a last flag. A 2-entry output buffer absorbs the BRAM's 1-cycle read latency, so the block runs at one word per cycle under no backpressure and loses nothing under backpressure.

Parameters:
DATA_WIDTH, 8, bits per activation element
PE_SIZE, 14, elements per BRAM2 word
OUT_CH, 64, output channels
MEM2_DATA_WIDTH, PE_SIZE*DATA_WIDTH (112), BRAM2 word width (derived)
MEM2_DEPTH, PE_SIZE*OUT_CH (896), words to drain (derived)
MEM2_ADDR_WIDTH, $clog2(MEM2_DEPTH) (10), BRAM2 address width (derived)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
drain_start_i  in  1  start pulse from GEMM control after the final BRAM2 write
drain_busy_o  out  1  high while a drain is in progress
drain_done_o  out  1  one-cycle pulse after the last handshake
mem2_ce0_o  out  1  BRAM2 port0 chip enable (read request)
mem2_we0_o  out  1  BRAM2 port0 write enable; constant 0
mem2_addr0_o  out  MEM2_ADDR_WIDTH  BRAM2 read address
mem2_q0_i  in  MEM2_DATA_WIDTH  BRAM2 read data; valid the cycle after ce0
m_valid_o  out  1  output word valid
m_ready_i  in  1  downstream ready
m_data_o  out  MEM2_DATA_WIDTH  output word; lane 0 at [DATA_WIDTH-1:0], passed through unmodified
m_last_o  out  1  high with the word read from address MEM2_DEPTH-1

Behaviour:
- Reset (async assert, sync release) clears all outputs and state:
  - drain_busy_o, drain_done_o, mem2_ce0_o, m_valid_o and m_last_o are 0.
  - mem2_addr0_o and m_data_o are 0.
  - Buffer is empty, in-flight flag is clear, FSM is in IDLE.
- FSM states: IDLE, READ, FLUSH, DONE.
  - IDLE: drain_start_i=1 → READ; read address counter := 0.
  - READ: issue reads. After issuing address MEM2_DEPTH-1 → FLUSH.
  - FLUSH: no reads. When the buffer is empty, nothing is in flight, and the last word has handshaked → DONE.
  - DONE: drain_done_o=1 for exactly one cycle → IDLE.
- drain_busy_o=1 in READ and FLUSH only.
- drain_start_i is ignored in READ, FLUSH and DONE.
- Handshake: a transfer occurs when m_valid_o & m_ready_i.
  - While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable.
  - m_valid_o never drops without a transfer.
- Read issue rule:
  - pending = buffer occupancy + in-flight (0/1); pop = transfer this cycle.
  - mem2_ce0_o = (state==READ) & (pending - pop < 2).
  - mem2_addr0_o = current counter value; the counter increments on each issued read.
  - mem2_ce0_o is combinational from m_ready_i; no other path from m_ready_i to outputs.
- The in-flight flag is set on issue and cleared the next cycle. mem2_q0_i is pushed into the buffer at that next cycle's edge.
- The buffer never overflows; occupancy is at most 2. Simultaneous push and pop keeps occupancy unchanged and preserves FIFO order.
- m_last_o is carried in the buffer alongside the word from address MEM2_DEPTH-1.
- Latency: start high in cycle 0 → ce0=1 with addr=0 in cycle 1 → first m_valid_o=1 in cycle 3.
- Throughput: with m_ready_i=1 throughout, one word per cycle.
- No address wrap: the counter stops after MEM2_DEPTH-1 and is reset to 0 only by the next start.
- Reset mid-drain: everything is aborted immediately and the buffer is discarded. The next start drains from address 0.

Test Plan:
1. Hold rst_n=0, then release → all outputs 0, drain_busy_o=0. Pulse m_ready_i with no start → no ce0 and no m_valid_o.
2. BRAM2 model with word k = {PE_SIZE{k[7:0]}}, m_ready_i=1, start in cycle 0:
   - m_valid_o rises in cycle 3 and stays high for 896 consecutive beats with data k in order.
   - m_last_o is set only on beat 895.
   - drain_done_o pulses in cycle 899; busy is high in cycles 1–898.
3. m_ready_i alternating 1,0,1,0 → all 896 words delivered exactly once, in order, with no duplicates. The checker confirms pending never exceeds 2 and data stays stable while stalled.
4. m_ready_i=0 for 20 cycles starting at beat 100 → ce0 stops once pending=2; m_data_o holds word 100. On release, beats continue 100, 101, 102, ... with no gap once streaming resumes.
5. Second drain_start_i at beat 50 → ignored; the run still ends at beat 895. A new start after drain_done_o drains again from address 0.
6. rst_n=0 asynchronously at beat 400 → m_valid_o, ce0 and busy drop within the same cycle. After release, a start produces data 0 as the first beat.
